// File: rtl/jackpot_multi.sv
// jackpot_multi: a one-hot light walks across N LEDs at a prescaled rate.
// Flipping the switch under the lit LED wins. Flipping any other switch
// restarts the walk from lane 0. Several motion modes are selectable.
module jackpot_multi #(
  parameter int N         = 4,
  parameter int TICK_DIV  = 12_500_000,
  parameter int BLINK_DIV = 4,
  parameter int SCORE_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N-1:0]       SWITCHES,
  input  logic [1:0]         MODE,
  output logic [N-1:0]       LEDS,
  output logic               WIN,
  output logic [SCORE_W-1:0] SCORE
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = $clog2(BLINK_DIV) + 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);
  localparam logic [N-1:0]  LANE0  = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {S_RUN, S_WIN} state_t;

  state_t               state_q, state_d;
  logic [N-1:0]         s1_q, s2_q, s3_q;
  logic [N-1:0]         leds_q, leds_d;   // holds pos while in RUN
  logic [PW-1:0]        presc_q, presc_d;
  logic [BW-1:0]        blink_q, blink_d;
  logic                 up_q, up_d;       // bounce direction, 1 = toward MSB
  logic [SCORE_W-1:0]   score_q, score_d;

  logic [N-1:0] edge_v;
  logic         tick;
  logic         up_eff;
  logic [N-1:0] bounce_step;

  assign edge_v = s2_q & ~s3_q;
  assign tick   = (presc_q == P_LAST);

  // Bounce never wraps: at an end lane the step always heads back inward.
  assign up_eff      = leds_q[N-1] ? 1'b0 : (leds_q[0] ? 1'b1 : up_q);
  assign bounce_step = up_eff ? {leds_q[N-2:0], 1'b0} : {1'b0, leds_q[N-1:1]};

  // Switch synchroniser; reset preloads every stage so held switches give no edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= SWITCHES;
      s2_q <= SWITCHES;
      s3_q <= SWITCHES;
    end else begin
      s1_q <= SWITCHES;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Game state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_RUN;
      leds_q  <= LANE0;
      presc_q <= '0;
      blink_q <= '0;
      up_q    <= 1'b1;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      leds_q  <= leds_d;
      presc_q <= presc_d;
      blink_q <= blink_d;
      up_q    <= up_d;
      score_q <= score_d;
    end
  end

  // Next state: switch edges beat a same-cycle tick, which is then dropped.
  always_comb begin
    state_d = state_q;
    leds_d  = leds_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    blink_d = blink_q;
    up_d    = up_q;
    score_d = score_q;
    unique case (state_q)
      S_RUN: begin
        if (edge_v != '0) begin
          presc_d = '0;
          if (edge_v == leds_q) begin
            state_d = S_WIN;
            leds_d  = '1;
            blink_d = '0;
            if (score_q != '1) score_d = score_q + 1'b1;
          end else begin
            leds_d = LANE0;
            up_d   = 1'b1;
          end
        end else if (MODE == 2'b11) begin
          presc_d = presc_q;
        end else if (tick) begin
          unique case (MODE)
            2'b00: leds_d = {leds_q[N-2:0], leds_q[N-1]};
            2'b01: leds_d = {leds_q[0], leds_q[N-1:1]};
            default: begin
              leds_d = bounce_step;
              up_d   = bounce_step[N-1] ? 1'b0 : (bounce_step[0] ? 1'b1 : up_eff);
            end
          endcase
        end
      end
      S_WIN: begin
        if (edge_v != '0) begin
          state_d = S_RUN;
          leds_d  = LANE0;
          presc_d = '0;
          up_d    = 1'b1;
        end else if (tick) begin
          if (blink_q == B_LAST) begin
            blink_d = '0;
            leds_d  = ~leds_q;
          end else begin
            blink_d = blink_q + 1'b1;
          end
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  assign LEDS  = leds_q;
  assign WIN   = (state_q == S_WIN);
  assign SCORE = score_q;

endmodule

// File: tb/tb_jackpot_multi.sv
// Bench for jackpot_multi: directed scenarios followed by random play, all
// checked every cycle against a lane-index reference model of the game.
module tb_jackpot_multi;
  localparam int N = 4, TD = 4, BD = 2, SW = 2;
  localparam int SMAX = (1 << SW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  SWITCHES = '0;
  logic [1:0]    MODE = 2'b00;
  logic [N-1:0]  LEDS;
  logic          WIN;
  logic [SW-1:0] SCORE;

  jackpot_multi #(.N(N), .TICK_DIV(TD), .BLINK_DIV(BD), .SCORE_W(SW)) dut (
    .clock(clock), .reset(reset), .SWITCHES(SWITCHES), .MODE(MODE),
    .LEDS(LEDS), .WIN(WIN), .SCORE(SCORE)
  );

  always #5 clock = ~clock;

  int vectors = 0, miscompares = 0;

  // reference model: lit lane as an index, direction as +1/-1
  int          m_lane, m_dir, m_cnt, m_blink, m_score;
  bit          m_win, m_lit;
  logic [N-1:0] h1, h2, h3;   // switch samples one, two and three edges old

  logic [N-1:0] cur_sw = '0;
  logic [1:0]   cur_mode = 2'b00;

  function automatic logic [N-1:0] exp_leds();
    if (m_win) return m_lit ? {N{1'b1}} : {N{1'b0}};
    return N'(1 << m_lane);
  endfunction

  task automatic model_step();
    logic [N-1:0] e;
    bit tk;
    if (reset) begin
      m_lane = 0; m_dir = 1; m_cnt = 0; m_blink = 0; m_score = 0;
      m_win = 0; m_lit = 0;
      h1 = SWITCHES; h2 = SWITCHES; h3 = SWITCHES;
      return;
    end
    e  = h2 & ~h3;
    tk = (m_cnt == TD - 1);
    if (!m_win) begin
      if (e != 0) begin
        m_cnt = 0;
        if (e == N'(1 << m_lane)) begin
          m_win = 1; m_lit = 1; m_blink = 0;
          m_score = (m_score < SMAX) ? m_score + 1 : SMAX;
        end else begin
          m_lane = 0; m_dir = 1;
        end
      end else if (MODE != 2'b11) begin
        m_cnt = tk ? 0 : m_cnt + 1;
        if (tk) begin
          case (MODE)
            2'b00: m_lane = (m_lane + 1) % N;
            2'b01: m_lane = (m_lane + N - 1) % N;
            default: begin
              if (m_lane == N - 1) m_dir = -1;
              else if (m_lane == 0) m_dir = 1;
              m_lane += m_dir;
              if (m_lane == N - 1) m_dir = -1;
              if (m_lane == 0) m_dir = 1;
            end
          endcase
        end
      end
    end else begin
      if (e != 0) begin
        m_win = 0; m_lane = 0; m_cnt = 0; m_dir = 1;
      end else begin
        m_cnt = tk ? 0 : m_cnt + 1;
        if (tk) begin
          if (m_blink == BD - 1) begin m_blink = 0; m_lit = !m_lit; end
          else m_blink++;
        end
      end
    end
    h3 = h2; h2 = h1; h1 = SWITCHES;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive at negedge, step model at posedge, compare just after
  task automatic cyc(input logic r);
    @(negedge clock);
    reset = r; SWITCHES = cur_sw; MODE = cur_mode;
    @(posedge clock);
    model_step();
    #1;
    chk("leds", 32'(LEDS), 32'(exp_leds()));
    chk("win", 32'(WIN), 32'(m_win));
    chk("score", 32'(SCORE), 32'(m_score));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1);
  endtask

  // bounded wait until the model shows lane/prescaler in RUN
  task automatic wait_pos(input int lane, input int cnt);
    int k;
    for (k = 0; k < 64; k++) begin
      if (!m_win && m_lane == lane && m_cnt == cnt) break;
      cyc(1'b0);
    end
    if (k == 64) begin
      vectors++; miscompares++;
      $display("FAIL wait_pos timeout lane=%0d cnt=%0d", lane, cnt);
    end
  endtask

  initial begin
    // 1: reset and rotate up
    cur_mode = 2'b00; cur_sw = '0;
    do_reset(3);
    chk("rst_leds", 32'(LEDS), 32'h1);
    chk("rst_win", 32'(WIN), 32'h0);
    chk("rst_score", 32'(SCORE), 32'h0);
    run(4);
    chk("first_move", 32'(LEDS), 32'h2);
    run(13);

    // 2: rotate down, pause, resume
    do_reset(1);
    cur_mode = 2'b01; run(4);
    chk("rot_down", 32'(LEDS), 32'h8);
    run(2);
    cur_mode = 2'b11; run(20);
    chk("paused", 32'(LEDS), 32'h8);
    cur_mode = 2'b01; run(8);

    // 3: bounce
    cur_mode = 2'b10; do_reset(1); run(28);
    chk("bounce_end", 32'(LEDS), 32'h2);

    // 4: hit, blink, exit
    cur_mode = 2'b00; do_reset(1);
    wait_pos(1, 0);
    cur_sw = 4'b0010; run(3);
    chk("hit_win", 32'(WIN), 32'h1);
    chk("hit_leds", 32'(LEDS), 32'hF);
    chk("hit_score", 32'(SCORE), 32'h1);
    run(20);
    cur_sw = 4'b0000; run(3);
    cur_sw = 4'b0001; run(3);
    chk("exit_win", 32'(WIN), 32'h0);
    chk("exit_leds", 32'(LEDS), 32'h1);
    chk("exit_score", 32'(SCORE), 32'h1);

    // 5: misses and hit coincident with tick
    cur_sw = '0; do_reset(1);
    wait_pos(2, 0);
    cur_sw = 4'b0001; run(3);
    chk("miss_leds", 32'(LEDS), 32'h1);
    chk("miss_score", 32'(SCORE), 32'h0);
    run(6);
    cur_sw = '0; do_reset(1);
    wait_pos(2, 0);
    cur_sw = 4'b1100; run(3);
    chk("multi_miss", 32'(LEDS), 32'h1);
    chk("multi_win", 32'(WIN), 32'h0);
    cur_sw = '0; do_reset(1);
    wait_pos(1, 1);
    cur_sw = 4'b0010; run(3);
    chk("tick_hit", 32'(WIN), 32'h1);

    // 6: reset during WIN, saturation, held switch through reset
    run(3);
    do_reset(1);
    chk("rstwin_leds", 32'(LEDS), 32'h1);
    chk("rstwin_win", 32'(WIN), 32'h0);
    chk("rstwin_score", 32'(SCORE), 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (m_win) begin cur_sw = 4'b1000; run(3); cur_sw = '0; run(3); end
      cur_sw = '0; run(2);
      wait_pos(1, 0);
      cur_sw = 4'b0010; run(3);
    end
    chk("saturate", 32'(SCORE), 32'h3);
    cur_sw = 4'b0010; do_reset(2); run(12);
    chk("held_win", 32'(WIN), 32'h0);
    chk("held_score", 32'(SCORE), 32'h0);

    // random play
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) cur_mode = 2'($urandom_range(3));
      if ($urandom_range(5) == 0) begin
        if (!m_win && $urandom_range(1) == 0) cur_sw = cur_sw ^ N'(1 << m_lane);
        else cur_sw[$urandom_range(N - 1)] ^= 1'b1;
      end
      cyc($urandom_range(299) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/jackpot_multi.md
# jackpot_multi

Parametrised successor to the four-lane jackpot game: a one-hot light walks across `N` LEDs at a prescaled rate, and the player flips the switch under the lit LED. A hit latches a blinking win display and bumps a saturating score. Miss handling, selectable motion modes (rotate left/right, bounce, pause) and switch synchronisation are new in this generation. The block sits between the board switch/LED pins and the rest of the lab top level, on the single 125 MHz clock.

## Interface
- `N`, 4: lane count (switches and LEDs); must be ≥ 2.
- `TICK_DIV`, 12_500_000: clocks per movement tick (0.1 s at 125 MHz); must be ≥ 2.
- `BLINK_DIV`, 4: ticks per win-display toggle; must be ≥ 1.
- `SCORE_W`, 8: score counter width.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `SWITCHES`  in  N  raw asynchronous slide switches.
- `MODE`  in  2  motion mode: 00 = rotate up (toward MSB), 01 = rotate down, 10 = bounce, 11 = pause.
- `LEDS`  out  N  registered LED drive.
- `WIN`  out  1  high while in WIN state.
- `SCORE`  out  SCORE_W  count of hits since reset.

## Operation
- **Reset values:** `LEDS`=…0001, `WIN`=0, `SCORE`=0, prescaler=0, blink counter=0, bounce direction=up, state=RUN.
- **Reset capture:** while `reset` is high, all three switch sync stages load `SWITCHES` directly. A switch held through reset therefore produces no edge.
- **Synchroniser:** stages s1←SWITCHES, s2←s1, s3←s2. Rising-edge vector is `e = s2 & ~s3`.
- **Prescaler:** counts 0..TICK_DIV-1. `tick` is asserted in the cycle the count equals TICK_DIV-1, and the count wraps to 0.
  - Frozen (holds its value) while MODE=11 and state=RUN.
  - Always runs in WIN.
- **State RUN:** internal one-hot `pos` drives `LEDS`.
  - **Hit:** `e == pos`. Go to WIN, set `LEDS`=all ones, set blink counter=0 and prescaler=0, and increment `SCORE` (saturates at all ones).
  - **Miss:** `e != 0` and `e != pos`. This includes multiple simultaneous edges, even when one of them is the lit lane. Set `pos`=…0001 and prescaler=0, and clear bounce direction to up. `SCORE` is unchanged.
  - **Priority:** hit/miss are evaluated against the currently displayed `pos` and take priority over a same-cycle `tick`. That tick is discarded.
  - **Tick with `e`=0:** `pos` moves according to `MODE`.
    - 00: rotate toward MSB, wrapping MSB→LSB.
    - 01: rotate toward LSB, wrapping LSB→MSB.
    - 10 (bounce): step in the stored direction. On reaching MSB the direction flips to down; on reaching LSB it flips to up. The next step after a flip moves away from the end, so the end lane is lit for exactly one tick.
    - 11: no movement.
  - **Mode changes** take effect at the next tick from the current `pos`. The direction register is only updated in mode 10 or by miss/reset.
- **State WIN:** `WIN`=1.
  - On each tick the blink counter increments. When it reaches BLINK_DIV-1 it wraps to 0 and `LEDS` toggles between all ones and all zeros.
  - Any `e != 0` returns to RUN with `pos`=…0001, prescaler=0 and direction=up; `SCORE` is retained.
  - `MODE` is ignored in WIN.
- **Reset** at any time, including mid-WIN or mid-tick, forces all reset values on the next edge.

## Timing
- **Switch to response:** if `SWITCHES` changes before rising edge k, it is in s1 at k and s2 at k+1 (`e` asserted combinationally during cycle k+1). `LEDS`, `WIN` and `SCORE` update at edge k+2.
- **Movement period:** `LEDS` moves exactly every TICK_DIV clocks. The first move after reset release or a prescaler clear occurs TICK_DIV clocks later.
- **Win blink period:** TICK_DIV·BLINK_DIV clocks per half-period. All ones is displayed first.
- **Outputs:** all registered; no combinational input-to-output path.
- **Widths:** `SCORE` is SCORE_W bits unsigned and saturating. Prescaler width is clog2(TICK_DIV); blink counter width is clog2(BLINK_DIV)+1.

## Test plan
All scenarios use N=4, TICK_DIV=4, BLINK_DIV=2, SCORE_W=2.
1. **Reset and rotate up:** hold reset 3 clocks, then MODE=00 → `LEDS`=0001, `WIN`=0, `SCORE`=0. After release `LEDS` steps 0010, 0100, 1000, 0001 every 4 clocks.
2. **Rotate down and pause:** MODE=01 from 0001 → 1000 after 4 clocks. Then MODE=11 for 20 clocks → `LEDS` frozen. Then MODE=01 → next step arrives after the remaining prescaler count.
3. **Bounce:** MODE=10 from reset → sequence 0010, 0100, 1000, 0100, 0010, 0001, 0010, one step per 4 clocks.
4. **Hit:** while `LEDS`=0010, raise `SWITCHES`=0010 → 3 edges later `LEDS`=1111, `WIN`=1, `SCORE`=01. `LEDS` then alternates 1111/0000 every 8 clocks. Then drop and re-raise switch 0 → `LEDS`=0001, `WIN`=0, `SCORE`=01.
5. **Miss:**
   - While `LEDS`=0100, raise switch 0 → `LEDS`=0001, `SCORE` unchanged, next move 4 clocks later.
   - Raise switches 2 and 3 in the same cycle while `LEDS`=0100 → treated as a miss.
   - Hit coincident with a tick → win against the pre-tick `LEDS`.
6. **Reset during WIN and saturation:**
   - Reset asserted during WIN → `LEDS`=0001, `WIN`=0, `SCORE`=0.
   - Four consecutive hits → `SCORE` stays 11 after the third.
   - A switch held high through reset → no hit or miss after release.
